dds_wavegen: RTL and testbench
==============================

# dds_wavegen

Parametrised direct-digital-synthesis waveform generator, successor to the fixed 16-position sine lookup. Combines a phase accumulator with a programmable frequency tuning word, a quarter-wave sine table with quadrant mirroring, and three additional waveform modes. One registered sample is produced per enabled cycle. The block drives the DAC/output byte of the top-level tile.

## Interface
Parameters:
- PHASE_W, 16, phase accumulator and tuning word width; must be ≥ ADDR_W+2 and ≥ OUT_W+1
- ADDR_W, 4, quarter-wave table address bits; table holds 2^ADDR_W+1 entries
- OUT_W, 8, sample width in offset binary; must be ≥ 2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  advance the accumulator and emit a sample this cycle
- ftw_in  in  PHASE_W  frequency tuning word
- ftw_load  in  1  capture ftw_in into the tuning word register
- phase_clr  in  1  synchronous clear of the phase accumulator
- mode  in  2  waveform: 0 sine, 1 square, 2 sawtooth, 3 triangle
- sample_out  out  OUT_W  registered waveform sample
- sample_valid  out  1  high one cycle after each ena cycle
- wrap  out  1  one-cycle pulse on accumulator carry-out

## Operation
- Registers: phase (PHASE_W), ftw (PHASE_W), sample_out, sample_valid, wrap.
- Reset values: phase 0, ftw 0, sample_out 2^(OUT_W-1) (midscale), sample_valid 0, wrap 0. Reset takes effect immediately when asserted, including mid-operation.
- ftw_load: ftw <= ftw_in. The new value is first used by the increment on the following cycle.
- Phase update, in priority order: if phase_clr, phase <= 0 and wrap <= 0, regardless of ena. Else if ena, {carry, phase} <= phase + ftw (mod 2^PHASE_W) and wrap <= carry. Otherwise phase holds and wrap <= 0.
- Output stage: when ena, sample_out <= f(phase, mode), using the phase register value before this cycle's update and the current mode. When ena is low, sample_out holds. sample_valid <= ena.
- Sine: A = 2^(OUT_W-1)-1, N = 2^ADDR_W, q(k) = round(A·sin(π·k/(2N))) for k = 0..N, with constants fixed at elaboration.
  - quad = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3 -: ADDR_W].
  - quad 0: 2^(OUT_W-1)+q(idx). quad 1: 2^(OUT_W-1)+q(N-idx). quad 2: 2^(OUT_W-1)-q(idx). quad 3: 2^(OUT_W-1)-q(N-idx).
  - Output range is 1 .. 2^OUT_W-1.
- Square: phase MSB 0 → all ones; MSB 1 → 0.
- Sawtooth: phase[PHASE_W-1 -: OUT_W].
- Triangle: t = phase[PHASE_W-2 -: OUT_W]; output t when MSB is 0, ~t when MSB is 1.
- Simultaneous events:
  - ftw_load with phase_clr: both apply.
  - phase_clr with ena: the clear wins for phase, and sample_out still updates from the old phase with sample_valid 1.
  - A mode change takes effect on the next sample with no phase disturbance.
- ftw = 0 with ena: constant output, wrap never asserts.

## Timing
- Sample latency is 1 cycle: the sample for phase P appears on the edge that advances P to P+ftw.
- sample_valid and sample_out update on the same edge.
- wrap is high in the cycle in which the phase register first shows the wrapped value.
- The tuning word takes effect 1 cycle after ftw_load.
- phase_clr takes effect on the next edge; the first post-clear sample (value f(0)) appears on the next ena edge.
- Throughput is 1 sample per ena cycle. The design has no stall or backpressure.

## Test plan
All scenarios use default parameters. Table values: q(0)=0, q(4)=49, q(8)=90, q(16)=127.
1. Reset, then hold ena low → sample_out 128, sample_valid 0, wrap 0, phase 0. Assert rst_n low mid-stream → outputs return to reset values without a clock edge.
2. ftw_load 0x1000, mode 0, then ena high for 17 cycles → samples 128, 177 (q(4)), 218, …, 255 at phase 0x4000, 128 at 0x8000, 1 at 0xC000, then 128 again. wrap pulses exactly once, on the 16th enabled edge.
3. ftw 0x0800, modes 1/2/3 over one period → square is 255 for 16 samples then 0 for 16. Saw steps by 8 from 0 to 248. Triangle is 0 at phase 0, 128 at 0x4000, 255 at 0x8000, and 127 at 0xC000.
4. ftw_load 0x2000 mid-run while ena is held → the increment on the load cycle uses the old ftw; the next increment adds 0x2000.
5. phase_clr pulsed with ena high at phase 0x6000 → that sample is f(0x6000) = 218; the phase register is 0; the next sample is 128; wrap stays 0.
6. ena toggling 1,0,0,1 → sample_valid 1,0,0,1 delayed by one cycle; phase and sample_out hold through the low cycles.

Source files
------------

// File: rtl/dds_wavegen.sv
// dds_wavegen: phase-accumulator DDS with quarter-wave sine table,
// plus square, sawtooth and triangle modes; one sample per ena cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ena               advance phase and register a new sample
//   ftw_in, ftw_load  tuning word and its load strobe
//   phase_clr         synchronous phase clear (wins over ena)
//   mode              0 sine, 1 square, 2 sawtooth, 3 triangle
//   sample_out        registered offset-binary sample
//   sample_valid      high the cycle after an ena cycle
//   wrap              pulse when the phase register shows a wrap
module dds_wavegen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 4,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic               phase_clr,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_e;

  localparam int N = 1 << ADDR_W;

  localparam logic [OUT_W-1:0] MID =
    {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [ADDR_W:0] N_A =
    {1'b1, {ADDR_W{1'b0}}};

  // Fixed-point scale for the elaboration-time sine series.
  localparam longint S_FX  = 64'sd1 <<< 28;
  localparam longint PI_FX = 64'sd843314857;

  // round(A * sin(pi*k/(2N))) via a Taylor series in 2^28
  // fixed point; products stay below 2^59, well inside 64 bits.
  function automatic logic [OUT_W-2:0] sin_q(input int k);
    longint x;
    longint term;
    longint sum;
    longint amp;
    longint r;
    x    = (PI_FX * longint'(k)) / longint'(2 * N);
    term = x;
    sum  = x;
    for (int i = 1; i <= 12; i++) begin
      term = (term * x) / S_FX;
      term = (term * x) / S_FX;
      term = -(term / longint'((2 * i) * (2 * i + 1)));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    r   = (amp * sum + S_FX / 2) / S_FX;
    return r[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] qtab [N+1];

  for (genvar k = 0; k <= N; k++) begin : g_qtab
    assign qtab[k] = sin_q(k);
  end

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] phase_nxt;
  logic               carry;

  assign {carry, phase_nxt} =
    {1'b0, phase} + {1'b0, ftw};

  // Sine: mirror the address in odd quadrants,
  // negate the amplitude in the lower half-cycle.
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   addr;
  logic [OUT_W-2:0]  qv;
  logic [OUT_W-1:0]  sine_val;

  assign quad = phase[PHASE_W-1 -: 2];
  assign idx  = phase[PHASE_W-3 -: ADDR_W];
  assign addr = quad[0] ? (N_A - {1'b0, idx})
                        : {1'b0, idx};
  assign qv   = qtab[addr];

  assign sine_val = quad[1] ? (MID - {1'b0, qv})
                            : (MID + {1'b0, qv});

  logic [OUT_W-1:0] sq_val;
  logic [OUT_W-1:0] saw_val;
  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] tri_val;

  assign sq_val  = {OUT_W{~phase[PHASE_W-1]}};
  assign saw_val = phase[PHASE_W-1 -: OUT_W];
  assign tri_t   = phase[PHASE_W-2 -: OUT_W];
  assign tri_val = phase[PHASE_W-1] ? ~tri_t : tri_t;

  mode_e            mode_sel;
  logic [OUT_W-1:0] wave;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    wave = MID;
    unique case (mode_sel)
      MODE_SINE:   wave = sine_val;
      MODE_SQUARE: wave = sq_val;
      MODE_SAW:    wave = saw_val;
      MODE_TRI:    wave = tri_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw <= '0;
    end else if (ftw_load) begin
      ftw <= ftw_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (phase_clr) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (ena) begin
      phase <= phase_nxt;
      wrap  <= carry;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Samples come from the pre-update phase, so a
  // clear in the same cycle does not affect them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= MID;
      sample_valid <= 1'b0;
    end else begin
      if (ena) sample_out <= wave;
      sample_valid <= ena;
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: directed bench for dds_wavegen at default parameters.
module tb_dds_wavegen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] ftw_in = '0;
  logic        ftw_load = 1'b0;
  logic        phase_clr = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_wavegen dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ftw_in(ftw_in),
    .ftw_load(ftw_load),
    .phase_clr(phase_clr),
    .mode(mode),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .wrap(wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    #12;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (sample_out !== 8'd128) begin
      failures++;
      $display("FAIL reset_sample got %0d want 128", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %0b want 0", sample_valid);
    end
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap got %0b want 0", wrap);
    end
    checks++;
    if (dut.phase !== 16'h0000) begin
      failures++;
      $display("FAIL reset_phase got %h want 0000", dut.phase);
    end
  endtask

  task automatic test_sine();
    logic [7:0] exp_s [17] = '{
      8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245,
      8'd218, 8'd177, 8'd128, 8'd79, 8'd38, 8'd11,
      8'd1, 8'd11, 8'd38, 8'd79, 8'd128};
    ftw_in = 16'h1000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    mode = 2'd0;
    ena = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      checks++;
      if (sample_out !== exp_s[k]) begin
        failures++;
        $display("FAIL sine_%0d got %0d want %0d",
                 k, sample_out, exp_s[k]);
      end
      checks++;
      if (wrap !== (k == 15)) begin
        failures++;
        $display("FAIL sine_wrap_%0d got %0b want %0b",
                 k, wrap, (k == 15));
      end
      checks++;
      if (sample_valid !== 1'b1) begin
        failures++;
        $display("FAIL sine_valid_%0d got %0b want 1",
                 k, sample_valid);
      end
    end
    ena = 1'b0;
    tick();
  endtask

  task automatic test_modes();
    logic [15:0] p;
    logic [7:0]  t;
    logic [7:0]  e;
    ftw_in = 16'h0800;
    ftw_load = 1'b1;
    phase_clr = 1'b1;
    tick();
    ftw_load = 1'b0;
    phase_clr = 1'b0;
    checks++;
    if (dut.ftw !== 16'h0800) begin
      failures++;
      $display("FAIL load_clr_ftw got %h want 0800", dut.ftw);
    end
    checks++;
    if (dut.phase !== 16'h0000) begin
      failures++;
      $display("FAIL load_clr_phase got %h want 0000", dut.phase);
    end
    ena = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      mode = m[1:0];
      for (int k = 0; k < 32; k++) begin
        tick();
        p = 16'(k * 16'h0800);
        t = p[14:7];
        case (m)
          1: e = (k < 16) ? 8'd255 : 8'd0;
          2: e = 8'(k * 8);
          default: e = p[15] ? ~t : t;
        endcase
        checks++;
        if (sample_out !== e) begin
          failures++;
          $display("FAIL mode%0d_%0d got %0d want %0d",
                   m, k, sample_out, e);
        end
      end
    end
    ena = 1'b0;
    tick();
  endtask

  task automatic test_ftw_reload();
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    mode = 2'd2;
    ena = 1'b1;
    tick();
    tick();
    ftw_in = 16'h2000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    checks++;
    if (dut.phase !== 16'h1800) begin
      failures++;
      $display("FAIL reload_old_phase got %h want 1800", dut.phase);
    end
    checks++;
    if (sample_out !== 8'h10) begin
      failures++;
      $display("FAIL reload_s0 got %h want 10", sample_out);
    end
    tick();
    checks++;
    if (dut.phase !== 16'h3800) begin
      failures++;
      $display("FAIL reload_new_phase got %h want 3800", dut.phase);
    end
    checks++;
    if (sample_out !== 8'h18) begin
      failures++;
      $display("FAIL reload_s1 got %h want 18", sample_out);
    end
    tick();
    checks++;
    if (sample_out !== 8'h38) begin
      failures++;
      $display("FAIL reload_s2 got %h want 38", sample_out);
    end
    ena = 1'b0;
    tick();
  endtask

  task automatic test_phase_clr();
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    mode = 2'd0;
    ena = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut.phase !== 16'h6000) begin
      failures++;
      $display("FAIL clr_pre_phase got %h want 6000", dut.phase);
    end
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    checks++;
    if (sample_out !== 8'd218) begin
      failures++;
      $display("FAIL clr_sample got %0d want 218", sample_out);
    end
    checks++;
    if (dut.phase !== 16'h0000) begin
      failures++;
      $display("FAIL clr_phase got %h want 0000", dut.phase);
    end
    checks++;
    if (sample_valid !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL clr_flags got v=%0b w=%0b want v=1 w=0",
               sample_valid, wrap);
    end
    tick();
    checks++;
    if (sample_out !== 8'd128) begin
      failures++;
      $display("FAIL clr_next got %0d want 128", sample_out);
    end
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL clr_next_wrap got %0b want 0", wrap);
    end
  endtask

  task automatic test_ena_toggle();
    logic       en_seq [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] s_exp  [4]  = '{8'd218, 8'd218, 8'd218, 8'd255};
    logic [15:0] p_exp [4]  = '{16'h4000, 16'h4000,
                                16'h4000, 16'h6000};
    for (int k = 0; k < 4; k++) begin
      ena = en_seq[k];
      tick();
      checks++;
      if (sample_valid !== en_seq[k]) begin
        failures++;
        $display("FAIL toggle_valid_%0d got %0b want %0b",
                 k, sample_valid, en_seq[k]);
      end
      checks++;
      if (sample_out !== s_exp[k]) begin
        failures++;
        $display("FAIL toggle_sample_%0d got %0d want %0d",
                 k, sample_out, s_exp[k]);
      end
      checks++;
      if (dut.phase !== p_exp[k]) begin
        failures++;
        $display("FAIL toggle_phase_%0d got %h want %h",
                 k, dut.phase, p_exp[k]);
      end
    end
    ena = 1'b0;
    tick();
  endtask

  task automatic test_zero_ftw();
    ftw_in = 16'h0000;
    ftw_load = 1'b1;
    phase_clr = 1'b1;
    tick();
    ftw_load = 1'b0;
    phase_clr = 1'b0;
    mode = 2'd0;
    ena = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (sample_out !== 8'd128 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL zero_ftw_%0d got s=%0d w=%0b want s=128 w=0",
                 k, sample_out, wrap);
      end
    end
    ena = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ftw_in = 16'h1000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    ena = 1'b1;
    tick();
    tick();
    checks++;
    if (sample_out !== 8'd177) begin
      failures++;
      $display("FAIL areset_pre got %0d want 177", sample_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample_out !== 8'd128) begin
      failures++;
      $display("FAIL areset_sample got %0d want 128", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL areset_flags got v=%0b w=%0b want 0 0",
               sample_valid, wrap);
    end
    checks++;
    if (dut.phase !== 16'h0000 || dut.ftw !== 16'h0000) begin
      failures++;
      $display("FAIL areset_regs got p=%h f=%h want 0000 0000",
               dut.phase, dut.ftw);
    end
    ena = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sine();
    test_modes();
    test_ftw_reload();
    test_phase_clr();
    test_ena_toggle();
    test_zero_ftw();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
